// File: rtl/adc_sample_buffer_pkg.sv
// -----------------------------------------------------------------------------
// adc_sample_buffer_pkg
// Shared ADC defines used by the converter stages and the sample buffer.
// Holds the default sample width and buffer depth so every stage in the
// converter chain agrees on them.
// No ports (package).
// -----------------------------------------------------------------------------
package adc_sample_buffer_pkg;

    // Width of one decimated sample leaving the converter output stage.
    localparam int ADC_DATA_WIDTH = 32;

    // Number of sample entries held by the buffer (power of two, >= 2).
    localparam int ADC_DEPTH = 16;

    // Width of a fill-level / threshold field: must hold 0..depth inclusive.
    function automatic int adc_lvl_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : adc_sample_buffer_pkg

// File: rtl/adc_sample_buffer_mem.sv
// -----------------------------------------------------------------------------
// sample_buf_mem
// DEPTH x DATA_WIDTH sample storage with one synchronous write port and one
// synchronous read port. The array itself is not reset; only the read data
// register is, so the bus side sees zero after reset.
//
// Ports:
//   clk       in   clock
//   rst       in   synchronous active-high reset (read register only)
//   wr_en_i   in   write strobe
//   wr_addr_i in   write address
//   wr_data_i in   write data
//   rd_en_i   in   read strobe; rd_data_o updates on the next edge
//   rd_addr_i in   read address
//   rd_data_o out  registered read data, holds when rd_en_i=0
// -----------------------------------------------------------------------------
module sample_buf_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_i,
    input  logic [ADDR_W-1:0]     wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_W-1:0]     rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read-before-write: when both ports hit the same address in one cycle
    // (full buffer, simultaneous write and read) the old entry is returned.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule : sample_buf_mem

// File: rtl/adc_sample_buffer.sv
// -----------------------------------------------------------------------------
// adc_sample_buffer
// Circular buffer between the ADC decimator and the bus. Samples are written
// when qualified and capture is enabled; the bus pulls the oldest sample with
// a one-cycle registered read. Tracks fill level, a sticky overflow flag for
// dropped samples and a registered level/overflow interrupt.
//
// Handshake: a sample is taken on any clock edge where sample_valid_in=1 and
// capture_en_in=1 unless clear_in is high or the buffer is full with no read
// accepted in the same cycle (then it is dropped and overflow_out set). There
// is no back-pressure toward the converter. A read is accepted on any edge
// where rd_en_in=1, the buffer is non-empty and clear_in=0; rd_valid_out then
// pulses for exactly one cycle with the data in rd_data_out.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   sample_in        decimated sample
//   sample_valid_in  single-cycle qualifier for sample_in
//   capture_en_in    0 discards samples silently
//   clear_in         synchronous flush (beats write and read)
//   rd_en_in         bus read request
//   thresh_in        level interrupt threshold, 0 disables
//   rd_data_out      registered read data
//   rd_valid_out     one-cycle qualifier for rd_data_out
//   level_out        entry count 0..DEPTH
//   empty_out        level_out == 0
//   full_out         level_out == DEPTH
//   overflow_out     sticky lost-sample flag
//   irq_out          registered interrupt
// -----------------------------------------------------------------------------
module adc_sample_buffer
    import adc_sample_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = ADC_DATA_WIDTH,
    parameter int DEPTH      = ADC_DEPTH,
    parameter int LVL_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  sample_valid_in,
    input  logic                  capture_en_in,
    input  logic                  clear_in,
    input  logic                  rd_en_in,
    input  logic [LVL_W-1:0]      thresh_in,
    output logic [DATA_WIDTH-1:0] rd_data_out,
    output logic                  rd_valid_out,
    output logic [LVL_W-1:0]      level_out,
    output logic                  empty_out,
    output logic                  full_out,
    output logic                  overflow_out,
    output logic                  irq_out
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             overflow_q, overflow_d;
    logic             irq_q, irq_d;
    logic             rd_valid_q;

    logic             empty;
    logic             full;
    logic             wr_attempt;
    logic             wr_acc;
    logic             rd_acc;

    // Flags come straight from the level register.
    assign empty = (level_q == '0);
    assign full  = (level_q == LVL_W'(DEPTH));

    // Reads are gated by empty, so an empty-buffer write+read never bypasses.
    assign rd_acc     = rd_en_in && !empty && !clear_in;
    assign wr_attempt = sample_valid_in && capture_en_in && !clear_in;
    // At full, a same-cycle read frees the slot the write lands in.
    assign wr_acc     = wr_attempt && (!full || rd_acc);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;

        if (clear_in) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (wr_acc && !rd_acc) begin
                level_d = level_q + LVL_W'(1);
            end else if (rd_acc && !wr_acc) begin
                level_d = level_q - LVL_W'(1);
            end
            if (wr_attempt && !wr_acc) begin
                overflow_d = 1'b1;
            end
        end

        // level_d never exceeds DEPTH, so thresholds above DEPTH never fire.
        irq_d = overflow_d || ((thresh_in != '0) && (level_d >= thresh_in));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            irq_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            irq_q      <= irq_d;
            rd_valid_q <= rd_acc;
        end
    end

    sample_buf_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (PTR_W)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_acc),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (sample_in),
        .rd_en_i   (rd_acc),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (rd_data_out)
    );

    assign rd_valid_out = rd_valid_q;
    assign level_out    = level_q;
    assign empty_out    = empty;
    assign full_out     = full;
    assign overflow_out = overflow_q;
    assign irq_out      = irq_q;

endmodule : adc_sample_buffer

// File: tb/tb_adc_sample_buffer.sv
// -----------------------------------------------------------------------------
// tb_adc_sample_buffer
// Self-checking bench for adc_sample_buffer. A reference FIFO model decides
// acceptance from its own state; data leaving the model on an accepted read
// is pushed to exp_q and popped when the DUT presents rd_valid_out.
// -----------------------------------------------------------------------------
module tb_adc_sample_buffer;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int LW    = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [DW-1:0] sample_in;
    logic          sample_valid_in;
    logic          capture_en_in;
    logic          clear_in;
    logic          rd_en_in;
    logic [LW-1:0] thresh_in;
    logic [DW-1:0] rd_data_out;
    logic          rd_valid_out;
    logic [LW-1:0] level_out;
    logic          empty_out;
    logic          full_out;
    logic          overflow_out;
    logic          irq_out;

    adc_sample_buffer dut (
        .clk             (clk),
        .rst             (rst),
        .sample_in       (sample_in),
        .sample_valid_in (sample_valid_in),
        .capture_en_in   (capture_en_in),
        .clear_in        (clear_in),
        .rd_en_in        (rd_en_in),
        .thresh_in       (thresh_in),
        .rd_data_out     (rd_data_out),
        .rd_valid_out    (rd_valid_out),
        .level_out       (level_out),
        .empty_out       (empty_out),
        .full_out        (full_out),
        .overflow_out    (overflow_out),
        .irq_out         (irq_out)
    );

    // ---------------- scoreboard / model ----------------
    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] fifo_m[$];
    logic [DW-1:0] exp_q[$];
    int            m_level;
    bit            m_ovf;
    bit            m_irq;
    bit            m_valid;
    logic [DW-1:0] m_data;

    task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check_val("level", DW'(level_out), DW'(m_level));
        check_val("empty", DW'(empty_out), DW'(m_level == 0));
        check_val("full", DW'(full_out), DW'(m_level == DEPTH));
        check_val("overflow", DW'(overflow_out), DW'(m_ovf));
        check_val("irq", DW'(irq_out), DW'(m_irq));
        check_val("rd_valid", DW'(rd_valid_out), DW'(m_valid));
        if (m_valid && exp_q.size() > 0) begin
            check_val("rd_data", rd_data_out, exp_q.pop_front());
        end else begin
            check_val("rd_data_hold", rd_data_out, m_data);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Drives one cycle of stimulus, advances the model, checks all outputs.
    task automatic cycle(input bit v, input logic [DW-1:0] d, input bit cap,
                         input bit rd, input bit clr);
        bit racc, wacc, att;
        sample_valid_in = v;
        sample_in       = d;
        capture_en_in   = cap;
        rd_en_in        = rd;
        clear_in        = clr;
        racc = rd && (m_level != 0) && !clr;
        wacc = v && cap && !clr && ((m_level != DEPTH) || racc);
        att  = v && cap && !clr && (m_level == DEPTH) && !racc;
        @(posedge clk);
        #1;
        if (clr) begin
            fifo_m.delete();
            m_ovf = 1'b0;
        end else begin
            if (racc) begin
                m_data = fifo_m.pop_front();
                exp_q.push_back(m_data);
            end
            if (wacc) fifo_m.push_back(d);
            if (att) m_ovf = 1'b1;
        end
        m_level = fifo_m.size();
        m_valid = racc;
        m_irq   = m_ovf || ((thresh_in != 0) && (m_level >= int'(thresh_in)));
        sample_valid_in = 1'b0;
        rd_en_in        = 1'b0;
        clear_in        = 1'b0;
        check_outputs();
    endtask

    task automatic wr(input logic [DW-1:0] d);
        cycle(1'b1, d, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic rd();
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic clr();
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    endtask

    // Reset asserted together with write, read and clear: reset must win.
    task automatic do_reset();
        rst             = 1'b1;
        sample_valid_in = 1'b1;
        sample_in       = 32'hDEAD_BEEF;
        capture_en_in   = 1'b1;
        rd_en_in        = 1'b1;
        clear_in        = 1'b1;
        @(posedge clk);
        #1;
        rst             = 1'b0;
        sample_valid_in = 1'b0;
        rd_en_in        = 1'b0;
        clear_in        = 1'b0;
        fifo_m.delete();
        exp_q.delete();
        m_level = 0;
        m_ovf   = 1'b0;
        m_irq   = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
        check_outputs();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst             = 1'b1;
        sample_in       = '0;
        sample_valid_in = 1'b0;
        capture_en_in   = 1'b1;
        clear_in        = 1'b0;
        rd_en_in        = 1'b0;
        thresh_in       = '0;
        @(posedge clk);
        #1;
        do_reset();

        // Fill 0x1..0x10, then one more write overflows.
        for (int i = 1; i <= DEPTH; i++) wr(DW'(i));
        wr(32'h11);
        // Drain back to back; the extra read sees an empty buffer.
        for (int i = 0; i < DEPTH; i++) rd();
        rd();
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        clr();

        // Wrap: 10/10 then 12/12.
        for (int i = 0; i < 10; i++) wr($urandom);
        for (int i = 0; i < 10; i++) rd();
        for (int i = 0; i < 12; i++) wr($urandom);
        for (int i = 0; i < 12; i++) rd();

        // Simultaneous write+read at full, then drain so 0xAA comes out last.
        for (int i = 0; i < DEPTH; i++) wr($urandom);
        cycle(1'b1, 32'hAA, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) rd();
        // Simultaneous write+read at empty: write only.
        cycle(1'b1, 32'h55, 1'b1, 1'b1, 1'b0);
        rd();

        // Level interrupt at threshold 4, then overflow forces irq.
        thresh_in = 5'd4;
        for (int i = 0; i < 4; i++) wr($urandom);
        rd();
        for (int i = 0; i < DEPTH; i++) wr($urandom);
        for (int i = 0; i < 12; i++) rd();
        clr();

        // Threshold above DEPTH never fires the level term.
        thresh_in = 5'd20;
        for (int i = 0; i < DEPTH; i++) wr($urandom);
        // Capture disabled at full: sample discarded, no overflow.
        cycle(1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
        // Overflow then drain to level 7; clear with a write beats everything.
        wr(32'h99);
        for (int i = 0; i < 9; i++) rd();
        thresh_in = 5'd3;
        cycle(1'b1, 32'h123, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Reset in the cycle after an accepted read, with a read still requested.
        for (int i = 0; i < 3; i++) wr($urandom);
        rd();
        do_reset();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 49) == 0) thresh_in = LW'($urandom_range(0, 20));
            cycle(bit'($urandom_range(0, 1)), $urandom,
                  $urandom_range(0, 7) != 0,
                  bit'($urandom_range(0, 1)),
                  $urandom_range(0, 63) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_adc_sample_buffer
